// File: rtl/ir_receiver.sv
// Pulse-distance IR frame decoder: recovers MESSAGE_LENGTH-bit letters (LSB first)
// from a demodulated IR line, pulsing data_valid_out per good frame and error_out per aborted one.
module ir_receiver #(
    parameter int MESSAGE_LENGTH     = 5,
    parameter int START_MARK_CYCLES  = 900000,
    parameter int START_SPACE_CYCLES = 450000,
    parameter int BIT_MARK_CYCLES    = 56250,
    parameter int ZERO_SPACE_CYCLES  = 56250,
    parameter int ONE_SPACE_CYCLES   = 168750,
    parameter int ACTIVE_LOW         = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      signal_in,
    output logic [MESSAGE_LENGTH-1:0] data_out,
    output logic                      data_valid_out,
    output logic                      error_out,
    output logic                      busy_out
);
    localparam int CW = $clog2(2 * START_MARK_CYCLES) + 1;
    localparam int BW = $clog2(MESSAGE_LENGTH + 1);
    localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    function automatic logic [CW-1:0] win_lo(input int n);
        return CW'(n - (n >> 2));
    endfunction

    function automatic logic [CW-1:0] win_hi(input int n);
        return CW'(n + (n >> 2));
    endfunction

    localparam logic [CW-1:0] SM_LO = win_lo(START_MARK_CYCLES);
    localparam logic [CW-1:0] SM_HI = win_hi(START_MARK_CYCLES);
    localparam logic [CW-1:0] SS_LO = win_lo(START_SPACE_CYCLES);
    localparam logic [CW-1:0] SS_HI = win_hi(START_SPACE_CYCLES);
    localparam logic [CW-1:0] BM_LO = win_lo(BIT_MARK_CYCLES);
    localparam logic [CW-1:0] BM_HI = win_hi(BIT_MARK_CYCLES);
    localparam logic [CW-1:0] ZS_LO = win_lo(ZERO_SPACE_CYCLES);
    localparam logic [CW-1:0] ZS_HI = win_hi(ZERO_SPACE_CYCLES);
    localparam logic [CW-1:0] OS_LO = win_lo(ONE_SPACE_CYCLES);
    localparam logic [CW-1:0] OS_HI = win_hi(ONE_SPACE_CYCLES);
    localparam logic [CW-1:0] BS_HI = (OS_HI > ZS_HI) ? OS_HI : ZS_HI;

    typedef enum logic [2:0] {
        IDLE,
        START_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    state_t                    state_q;
    logic                      sync1_q, sync2_q, mark_prev_q;
    logic [CW-1:0]             cnt_q, cnt_d, limit_s;
    logic [MESSAGE_LENGTH-1:0] shift_q, data_q;
    logic [BW-1:0]             bit_idx_q;
    logic                      valid_q, error_q;
    logic                      mark_s, edge_s, timeout_s;
    logic                      sm_ok, ss_ok, bm_ok, zero_ok, one_ok;

    assign mark_s = sync2_q ^ IDLE_LEVEL;
    assign edge_s = mark_s != mark_prev_q;

    // cnt_q at an edge equals the length in cycles of the interval that edge closes
    always_comb begin
        cnt_d = cnt_q;
        if (edge_s) begin
            cnt_d = CW'(1);
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign sm_ok   = (cnt_q >= SM_LO) && (cnt_q <= SM_HI);
    assign ss_ok   = (cnt_q >= SS_LO) && (cnt_q <= SS_HI);
    assign bm_ok   = (cnt_q >= BM_LO) && (cnt_q <= BM_HI);
    assign zero_ok = (cnt_q >= ZS_LO) && (cnt_q <= ZS_HI);
    assign one_ok  = (cnt_q >= OS_LO) && (cnt_q <= OS_HI);

    always_comb begin
        limit_s = BM_HI;
        unique case (state_q)
            START_SPACE: limit_s = SS_HI;
            BIT_SPACE:   limit_s = BS_HI;
            default:     limit_s = BM_HI;
        endcase
    end

    assign timeout_s = (state_q != IDLE) && !edge_s && (cnt_q > limit_s);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q     <= IDLE_LEVEL;
            sync2_q     <= IDLE_LEVEL;
            mark_prev_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            sync1_q     <= signal_in;
            sync2_q     <= sync1_q;
            mark_prev_q <= mark_s;
            cnt_q       <= cnt_d;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            if (timeout_s) begin
                error_q <= 1'b1;
                state_q <= IDLE;
            end else if (edge_s) begin
                unique case (state_q)
                    IDLE: begin
                        // Marks outside the start window are noise, not errors
                        if (!mark_s && sm_ok) state_q <= START_SPACE;
                    end
                    START_SPACE: begin
                        if (ss_ok) begin
                            state_q   <= BIT_MARK;
                            shift_q   <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    BIT_MARK: begin
                        if (bm_ok) begin
                            state_q <= BIT_SPACE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    BIT_SPACE: begin
                        if (zero_ok || one_ok) begin
                            shift_q   <= {!zero_ok, shift_q[MESSAGE_LENGTH-1:1]};
                            bit_idx_q <= bit_idx_q + BW'(1);
                            state_q   <= (bit_idx_q == BW'(MESSAGE_LENGTH - 1)) ? STOP_MARK : BIT_MARK;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    STOP_MARK: begin
                        if (bm_ok) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign error_out      = error_q;
    assign busy_out       = (state_q != IDLE);
endmodule

// File: tb/tb_ir_receiver.sv
// Bench for ir_receiver: directed and randomized frames judged by an interval-level
// reference model that predicts the outcome, its timing and the decoded letter.
module tb_ir_receiver;
    localparam int ML  = 5;
    localparam int SMC = 80;
    localparam int SSC = 40;
    localparam int BMC = 8;
    localparam int ZC  = 8;
    localparam int OC  = 24;
    localparam int INF = 1000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig = 1'b1;
    logic [ML-1:0] data;
    logic          valid, err, busy;

    always #5 clk = ~clk;

    ir_receiver #(
        .MESSAGE_LENGTH(ML), .START_MARK_CYCLES(SMC), .START_SPACE_CYCLES(SSC),
        .BIT_MARK_CYCLES(BMC), .ZERO_SPACE_CYCLES(ZC), .ONE_SPACE_CYCLES(OC), .ACTIVE_LOW(1)
    ) dut (
        .clk_in(clk), .rst_in(rst), .signal_in(sig),
        .data_out(data), .data_valid_out(valid), .error_out(err), .busy_out(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int v_cnt = 0, e_cnt = 0, v_cyc = -1, e_cyc = -1, both_cnt = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (valid) begin v_cnt <= v_cnt + 1; v_cyc <= cyc; end
        if (err)   begin e_cnt <= e_cnt + 1; e_cyc <= cyc; end
        if (valid && err) both_cnt <= both_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int checks = 0, failures = 0;
    int durs[0:15];
    int tchg[0:16];
    logic [ML-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit inw(input int d, input int n);
        return (d >= n - (n >> 2)) && (d <= n + (n >> 2));
    endfunction

    // Interval list: mark, space, 5 x (mark, space), stop mark; all scaled by num/den
    task automatic build(input logic [ML-1:0] letter, input int num, input int den);
        durs[0] = SMC * num / den;
        durs[1] = SSC * num / den;
        for (int k = 0; k < ML; k++) begin
            durs[2 + 2*k] = BMC * num / den;
            durs[3 + 2*k] = (letter[k] ? OC : ZC) * num / den;
        end
        durs[12] = BMC * num / den;
    endtask

    // kind: 0 nothing, 1 letter delivered, 2 error; ev = cycle the pulse is seen
    task automatic predict(input int n, output int kind, output int ev, output logic [ML-1:0] pd);
        int d, lim;
        bit ok;
        kind = 0; ev = -1; pd = '0;
        if (!inw(durs[0], SMC)) return;
        for (int i = 1; i <= 12; i++) begin
            d = (i < n) ? durs[i] : INF;
            if (i == 1) begin
                ok = inw(d, SSC); lim = SSC + (SSC >> 2);
            end else if (i % 2 == 0) begin
                ok = inw(d, BMC); lim = BMC + (BMC >> 2);
            end else begin
                ok = inw(d, ZC) || inw(d, OC);
                lim = (OC + (OC >> 2) > ZC + (ZC >> 2)) ? OC + (OC >> 2) : ZC + (ZC >> 2);
                pd[(i - 3) / 2] = !inw(d, ZC);
            end
            if (!ok) begin
                kind = 2;
                ev = tchg[i] + ((d > lim) ? lim + 1 : d) + 3;
                return;
            end
        end
        kind = 1;
        ev = tchg[13] + 3;
    endtask

    task automatic send_part(input int n);
        for (int i = 0; i < n; i++) begin
            tchg[i] = cyc;
            sig = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (durs[i]) @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string tag, input int n);
        int v0, e0, b0, kind, ev;
        logic [ML-1:0] pd;
        v0 = v_cnt; e0 = e_cnt; b0 = both_cnt;
        send_part(n);
        tchg[n] = cyc;
        sig = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        predict(n, kind, ev, pd);
        if (kind == 1) exp_data = pd;
        chk({tag, "_valid_count"}, v_cnt - v0, (kind == 1) ? 1 : 0);
        chk({tag, "_error_count"}, e_cnt - e0, (kind == 2) ? 1 : 0);
        if (kind == 1) chk({tag, "_valid_cycle"}, v_cyc, ev);
        if (kind == 2) chk({tag, "_error_cycle"}, e_cyc, ev);
        chk({tag, "_data_out"}, data, exp_data);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_both_high"}, both_cnt - b0, 0);
        $display("frame %s: n=%0d model_kind=%0d data_out=%0d", tag, n, kind, data);
    endtask

    initial begin
        int bz0, j;
        logic [ML-1:0] letter;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_data", data, 0);
        chk("reset_valid", valid, 0);
        chk("reset_error", err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        build(5'b10011, 100, 100); run("nominal_19", 13);
        build(5'b00000, 100, 100); run("b2b_0", 13);
        build(5'b11001, 100, 100); run("b2b_25", 13);

        build(5'b10110, 100, 100);
        send_part(5);
        #2 rst = 1'b1;
        #1;
        chk("midreset_data", data, 0);
        chk("midreset_valid", valid, 0);
        chk("midreset_error", err, 0);
        chk("midreset_busy", busy, 0);
        exp_data = '0;
        sig = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        build(5'b00001, 100, 100); run("after_reset_1", 13);

        build(5'($urandom_range(0, 31)), 124, 100); run("plus24", 13);
        build(5'($urandom_range(0, 31)), 76, 100);  run("minus24", 13);
        build(5'b01010, 130, 100); durs[0] = SMC;   run("plus30", 13);

        bz0 = busy_cnt;
        durs[0] = 20; run("glitch", 1);
        chk("glitch_busy_cycles", busy_cnt - bz0, 0);

        build(5'b11111, 100, 100); run("stuck_bit2", 7);

        for (int it = 0; it < 10; it++) begin
            letter = 5'($urandom_range(0, 31));
            build(letter, 100, 100);
            for (int i = 0; i < 13; i++)
                durs[i] = durs[i] + $urandom_range(0, 2 * (durs[i] / 5)) - durs[i] / 5;
            if (it % 2 == 1) begin
                j = $urandom_range(1, 12);
                durs[j] = $urandom_range(1, 50);
            end
            run($sformatf("random%0d", it), 13);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
